// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the Finger-Dancer player-input path.
//   SW_WIDTH   - number of slide switches
//   ST_*       - round FSM state encoding
//   CHANGE_MAX - saturation value of the per-round change counter
//   sat_inc()  - saturating increment for the change counter
package game_pkg;

    localparam int SW_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [3:0] CHANGE_MAX = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ARMED = ST_ARMED,
        S_HOLD  = ST_HOLD
    } state_e;

    // Saturating increment: holds at CHANGE_MAX instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == CHANGE_MAX) ? v : (v + 4'd1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser, debounce counter and stable flop
// for one switch bit.
//   i_clk         - board clock
//   i_rst_n       - asynchronous active-low reset
//   i_raw         - raw switch level, asynchronous to i_clk
//   o_stable      - debounced level (registered)
//   o_stable_next - value o_stable takes on the next edge
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable,
    output logic o_stable_next
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    // The disagreement has lasted DEBOUNCE_CYCLES edges once the counter
    // sits at its last value and the synchronised bit still differs.
    assign w_expire = (r_sync2 != r_stable) && (r_cnt == LP_LAST);

    // Look-ahead of the stable flop, used by the change detector.
    always_comb begin
        o_stable_next = r_stable;
        if (w_expire) begin
            o_stable_next = r_sync2;
        end else begin
            o_stable_next = r_stable;
        end
    end

    // Two-flop synchroniser for the asynchronous raw level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce counter and stable value; any agreeing cycle restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/switch_reader.sv
// switch_reader: player-input front end. Debounces the slide switches,
// counts stable-value changes during a round and hands one captured
// answer to the round logic over a valid/ack handshake.
//   board_clk    - system clock
//   rst_btn      - asynchronous active-low reset
//   sw_raw       - raw switch levels (asynchronous)
//   round_start  - pulse: arm capture for a new round
//   round_end    - pulse: close the round and capture the answer
//   sw_stable    - live debounced switch levels
//   answer       - captured answer, held until acknowledged
//   answer_valid - answer is available
//   answer_ack   - consumer has taken the answer
//   change_count - stable-value changes in current/last round (saturating)
//   armed        - FSM is in ARMED
module switch_reader
    import game_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             board_clk,
    input  logic             rst_btn,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             round_start,
    input  logic             round_end,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] answer,
    output logic             answer_valid,
    input  logic             answer_ack,
    output logic [3:0]       change_count,
    output logic             armed
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_stable_next;
    logic             w_changed;

    state_e           r_state;
    logic [WIDTH-1:0] r_answer;
    logic             r_valid;
    logic [3:0]       r_count;
    logic             r_armed;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .i_clk         (board_clk),
                .i_rst_n       (rst_btn),
                .i_raw         (sw_raw[g]),
                .o_stable      (w_stable[g]),
                .o_stable_next (w_stable_next[g])
            );
        end
    endgenerate

    // Bits flipping together on one edge count as a single change.
    assign w_changed = (w_stable_next != w_stable);

    // Round FSM with registered answer, handshake, change count and armed flag.
    always_ff @(posedge board_clk or negedge rst_btn) begin
        if (!rst_btn) begin
            r_state  <= S_IDLE;
            r_answer <= '0;
            r_valid  <= 1'b0;
            r_count  <= 4'd0;
            r_armed  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (round_start) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                        r_count <= 4'd0;
                    end else begin
                        r_armed <= 1'b0;
                    end
                end
                S_ARMED: begin
                    // round_end wins over a simultaneous round_start; the
                    // answer is the stable value before this edge's update.
                    if (round_end) begin
                        r_state  <= S_HOLD;
                        r_armed  <= 1'b0;
                        r_answer <= w_stable;
                        r_valid  <= 1'b1;
                        if (w_changed) begin
                            r_count <= sat_inc(r_count);
                        end else begin
                            r_count <= r_count;
                        end
                    end else if (round_start) begin
                        r_count <= 4'd0;
                    end else if (w_changed) begin
                        r_count <= sat_inc(r_count);
                    end else begin
                        r_count <= r_count;
                    end
                end
                S_HOLD: begin
                    if (answer_ack) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign sw_stable    = w_stable;
    assign answer       = r_answer;
    assign answer_valid = r_valid;
    assign change_count = r_count;
    assign armed        = r_armed;

endmodule

// File: tb/tb_switch_reader.sv
module tb_switch_reader;

    localparam int DEB = 4;

    logic       clk;
    logic       rst_btn;
    logic [3:0] sw_raw;
    logic       round_start;
    logic       round_end;
    logic [3:0] sw_stable;
    logic [3:0] answer;
    logic       answer_valid;
    logic       answer_ack;
    logic [3:0] change_count;
    logic       armed;

    int errors = 0;
    int checks = 0;

    switch_reader #(.WIDTH(4), .DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .board_clk    (clk),
        .rst_btn      (rst_btn),
        .sw_raw       (sw_raw),
        .round_start  (round_start),
        .round_end    (round_end),
        .sw_stable    (sw_stable),
        .answer       (answer),
        .answer_valid (answer_valid),
        .answer_ack   (answer_ack),
        .change_count (change_count),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The raw level seen by the debouncer is the one sampled two edges earlier;
    // a bit's stable value flips after DEB consecutive disagreeing edges.
    logic [3:0] rawq[$] = '{4'd0, 4'd0};
    logic [3:0] m_stable = 4'd0;
    logic [3:0] m_ans = 4'd0;
    logic       m_valid = 1'b0;
    int         m_cnt = 0;
    int         m_st = 0;      // 0 idle, 1 armed, 2 hold
    int         m_run[4] = '{0, 0, 0, 0};
    logic [3:0] seen;
    logic [3:0] old_st;
    bit         chg;

    always @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            rawq     = '{4'd0, 4'd0};
            m_stable = 4'd0;
            m_ans    = 4'd0;
            m_valid  = 1'b0;
            m_cnt    = 0;
            m_st     = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            seen = rawq.pop_front();
            rawq.push_back(sw_raw);
            old_st = m_stable;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = seen[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            chg = (m_stable != old_st);
            if (m_st == 0) begin
                if (round_start) begin m_st = 1; m_cnt = 0; end
            end else if (m_st == 1) begin
                if (round_end) begin
                    m_st = 2; m_ans = old_st; m_valid = 1'b1;
                    if (chg && m_cnt < 15) m_cnt = m_cnt + 1;
                end else if (round_start) begin
                    m_cnt = 0;
                end else if (chg && m_cnt < 15) begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                if (answer_ack) begin m_st = 0; m_valid = 1'b0; end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #2;
        checks++;
        if (sw_stable !== m_stable || answer !== m_ans || answer_valid !== m_valid ||
            change_count !== 4'(m_cnt) || armed !== (m_st == 1)) begin
            errors++;
            $display("FAIL model_cmp t=%0t stable=%b/%b answer=%b/%b valid=%b/%b count=%0d/%0d armed=%b/%b (got/exp)",
                     $time, sw_stable, m_stable, answer, m_ans, answer_valid, m_valid,
                     change_count, m_cnt, armed, (m_st == 1));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit s, input bit e, input bit a);
        round_start = s; round_end = e; answer_ack = a;
        @(negedge clk);
        round_start = 1'b0; round_end = 1'b0; answer_ack = 1'b0;
    endtask

    initial begin
        rst_btn = 1'b0; sw_raw = 4'b1111;
        round_start = 1'b0; round_end = 1'b0; answer_ack = 1'b0;
        tick(3);
        check("rst_stable", {4'd0, sw_stable}, 8'h00);
        check("rst_valid", {7'd0, answer_valid}, 8'h00);
        rst_btn = 1'b1;
        check("rel_count", {4'd0, change_count}, 8'h00);
        check("rel_armed", {7'd0, armed}, 8'h00);
        tick(5);
        check("stable_edge5", {4'd0, sw_stable}, 8'h00);
        tick(1);
        check("stable_edge6", {4'd0, sw_stable}, 8'h0F);

        // glitch shorter than the debounce window
        sw_raw = 4'b0000; tick(10);
        sw_raw = 4'b0100; tick(3);
        sw_raw = 4'b0000; tick(10);
        check("glitch_stable", {4'd0, sw_stable}, 8'h00);
        check("glitch_count", {4'd0, change_count}, 8'h00);

        // normal round
        pulse(1'b1, 1'b0, 1'b0);
        check("armed_on", {7'd0, armed}, 8'h01);
        sw_raw = 4'b0000; tick(10);
        sw_raw = 4'b0101; tick(10);
        sw_raw = 4'b0111; tick(10);
        pulse(1'b0, 1'b1, 1'b0);
        check("round_answer", {4'd0, answer}, 8'h07);
        check("round_valid", {7'd0, answer_valid}, 8'h01);
        check("round_count", {4'd0, change_count}, 8'h02);
        pulse(1'b0, 1'b0, 1'b1);
        check("ack_valid", {7'd0, answer_valid}, 8'h00);
        check("ack_answer", {4'd0, answer}, 8'h07);
        check("ack_armed", {7'd0, armed}, 8'h00);

        // saturation
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            sw_raw[0] = ~sw_raw[0];
            tick(8);
        end
        pulse(1'b0, 1'b1, 1'b0);
        check("sat_count", {4'd0, change_count}, 8'h0F);
        pulse(1'b0, 1'b0, 1'b1);
        tick(2);

        // simultaneous start/end, then start ignored in HOLD
        pulse(1'b1, 1'b0, 1'b0);
        tick(2);
        pulse(1'b1, 1'b1, 1'b0);
        check("both_valid", {7'd0, answer_valid}, 8'h01);
        check("both_armed", {7'd0, armed}, 8'h00);
        pulse(1'b1, 1'b0, 1'b0);
        tick(1);
        check("hold_start_armed", {7'd0, armed}, 8'h00);
        check("hold_start_valid", {7'd0, answer_valid}, 8'h01);
        pulse(1'b0, 1'b0, 1'b1);
        tick(2);

        // asynchronous reset while holding 1010
        sw_raw = 4'b1010; tick(10);
        pulse(1'b1, 1'b0, 1'b0);
        tick(2);
        pulse(1'b0, 1'b1, 1'b0);
        check("pre_rst_answer", {4'd0, answer}, 8'h0A);
        #3 rst_btn = 1'b0;
        #1;
        check("async_answer", {4'd0, answer}, 8'h00);
        check("async_valid", {7'd0, answer_valid}, 8'h00);
        check("async_stable", {4'd0, sw_stable}, 8'h00);
        check("async_armed", {7'd0, armed}, 8'h00);
        @(negedge clk);
        rst_btn = 1'b1;
        tick(10);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) sw_raw = 4'($urandom_range(0, 15));
            round_start = ($urandom_range(0, 19) == 0);
            round_end   = ($urandom_range(0, 24) == 0);
            answer_ack  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        round_start = 1'b0; round_end = 1'b0; answer_ack = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
